// File: rtl/dmem_line_buffer_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_types
//  Shared types for the data-memory line buffer.
//   rv32i_word  : 32-bit CPU word
//   cacheline_t : one 256-bit memory line (8 words)
//   dlb_state_t : line-buffer controller states (IDLE, WRITEBACK, FILL)
//  Helper line_word() extracts one 32-bit word from a line by word index.
// -----------------------------------------------------------------------------
package rv32i_types;

    typedef logic [31:0]  rv32i_word;
    typedef logic [255:0] cacheline_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } dlb_state_t;

    // Word idx occupies bits [idx*32 +: 32] of the line.
    function automatic rv32i_word line_word(input cacheline_t line, input logic [2:0] idx);
        return line[{idx, 5'b00000} +: 32];
    endfunction

endpackage

// File: rtl/dmem_line_buffer_chk.sv
// -----------------------------------------------------------------------------
// dmem_line_buffer_chk
//  Protocol checker for dmem_line_buffer, instantiated alongside the block.
//  Ports (all inputs): clk, rst (active-low), mem_read, mem_write,
//   pmem_read, pmem_write.
//  Flags a simultaneous load+store request (serviced as a store by the block)
//  and any overlap of pmem read and write requests.
// -----------------------------------------------------------------------------
module dmem_line_buffer_chk (
    input logic clk,
    input logic rst,
    input logic mem_read,
    input logic mem_write,
    input logic pmem_read,
    input logic pmem_write
);

    a_no_read_and_write: assert property (@(posedge clk) disable iff (!rst)
        !(mem_read && mem_write));

    a_pmem_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(pmem_read && pmem_write));

endmodule

// File: rtl/dmem_line_buffer_line_byte_merge.sv
// -----------------------------------------------------------------------------
// line_byte_merge
//  Combinational store merge: overwrites the enabled byte lanes of one word of
//  a 256-bit line with lane-aligned store data.
//  Ports:
//   line_i        in  256  current line contents
//   word_idx_i    in  3    word within the line being stored to
//   wdata_i       in  32   lane-aligned store data
//   byte_enable_i in  4    byte lanes to write (bit k -> bits [8k+7:8k])
//   line_o        out 256  line with the merge applied
// -----------------------------------------------------------------------------
module line_byte_merge
    import rv32i_types::*;
(
    input  cacheline_t   line_i,
    input  logic [2:0]   word_idx_i,
    input  rv32i_word    wdata_i,
    input  logic [3:0]   byte_enable_i,
    output cacheline_t   line_o
);

    // Per-lane select between store data and the existing line byte.
    always_comb begin
        line_o = line_i;
        for (int b = 0; b < 4; b++) begin
            if (byte_enable_i[b]) begin
                line_o[{word_idx_i, b[1:0], 3'b000} +: 8] = wdata_i[8*b +: 8];
            end else begin
                line_o[{word_idx_i, b[1:0], 3'b000} +: 8] = line_i[{word_idx_i, b[1:0], 3'b000} +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_line_buffer.sv
// -----------------------------------------------------------------------------
// dmem_line_buffer
//  Single-line write-back, write-allocate buffer between the CPU data port
//  (32-bit words, byte enables) and the 256-bit physical memory port.
//  Hits complete in the request cycle; misses write back a dirty line, fill
//  the requested line, and then hit on return to IDLE.
//  Ports:
//   clk, rst (async, active-low)
//   mem_read/mem_write/mem_address/mem_wdata/mem_byte_enable  CPU request
//   mem_rdata/mem_resp                                        CPU response
//   pmem_read/pmem_write/pmem_address/pmem_wdata              pmem request
//   pmem_rdata/pmem_resp                                      pmem response
// -----------------------------------------------------------------------------
module dmem_line_buffer
    import rv32i_types::*;
#(
    parameter int OFFSET_W = 5,
    parameter int TAG_W    = 32 - OFFSET_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [31:0]   mem_address,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_byte_enable,
    output logic [31:0]   mem_rdata,
    output logic          mem_resp,
    output logic          pmem_read,
    output logic          pmem_write,
    output logic [31:0]   pmem_address,
    output logic [255:0]  pmem_wdata,
    input  logic [255:0]  pmem_rdata,
    input  logic          pmem_resp
);

    dlb_state_t          state_q, state_d;
    logic                valid_q, valid_d;
    logic                dirty_q, dirty_d;
    logic [TAG_W-1:0]    tag_q,   tag_d;
    cacheline_t          line_q,  line_d;

    logic                req_s;
    logic                hit_s;
    logic [2:0]          word_idx_s;
    cacheline_t          merged_line_s;
    logic                unused_addr_s;

    assign req_s         = mem_read | mem_write;
    assign hit_s         = valid_q && (tag_q == mem_address[31:OFFSET_W]);
    assign word_idx_s    = mem_address[4:2];
    assign unused_addr_s = ^mem_address[1:0];

    // Read data is always the addressed word of the held line; the consumer
    // only looks at it while mem_resp is high.
    assign mem_rdata  = line_word(line_q, word_idx_s);
    assign pmem_wdata = line_q;

    line_byte_merge u_merge (
        .line_i        (line_q),
        .word_idx_i    (word_idx_s),
        .wdata_i       (mem_wdata),
        .byte_enable_i (mem_byte_enable),
        .line_o        (merged_line_s)
    );

    // State, tag/valid/dirty and line registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            dirty_q <= 1'b0;
            tag_q   <= {TAG_W{1'b0}};
            line_q  <= {256{1'b0}};
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tag_q   <= tag_d;
            line_q  <= line_d;
        end
    end

    // Next-state and output decode for the hit / write-back / fill sequence.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        tag_d        = tag_q;
        line_d       = line_q;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 32'h0000_0000;

        case (state_q)
            IDLE: begin
                if (req_s) begin
                    if (hit_s) begin
                        mem_resp = 1'b1;
                        // mem_write wins if both are raised; an all-zero
                        // byte enable leaves line and dirty untouched.
                        if (mem_write && (mem_byte_enable != 4'b0000)) begin
                            line_d  = merged_line_s;
                            dirty_d = 1'b1;
                        end else begin
                            line_d  = line_q;
                            dirty_d = dirty_q;
                        end
                    end else if (dirty_q) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q, {OFFSET_W{1'b0}}};
                if (pmem_resp) begin
                    dirty_d = 1'b0;
                    state_d = FILL;
                end else begin
                    state_d = WRITEBACK;
                end
            end

            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {mem_address[31:OFFSET_W], {OFFSET_W{1'b0}}};
                // The request (if still present) hits on the following cycle.
                if (pmem_resp) begin
                    line_d  = pmem_rdata;
                    tag_d   = mem_address[31:OFFSET_W];
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = FILL;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
